// File: rtl/fsm_experiment_sequencer_pkg.sv
// ============================================================================
// fsm_experiment_sequencer_pkg : state codes and helpers for the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package fsm_experiment_sequencer_pkg;

   localparam int STATE_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE       = 8'h00,
      ST_WAIT_READY = 8'h01,
      ST_WAIT_PHASE = 8'h02,
      ST_WAIT_FG    = 8'h03,
      ST_DETONATE   = 8'h04,
      ST_WAIT_WIRE  = 8'h05,
      ST_TRIGGER    = 8'h06,
      ST_DONE       = 8'h07,
      ST_FAULT      = 8'hFF
   } state_t;

   // Bit positions of the conditioned asynchronous inputs
   localparam int c_IN_START = 0;
   localparam int c_IN_READY = 1;
   localparam int c_IN_FG    = 2;
   localparam int c_IN_PHASE = 3;
   localparam int c_IN_WIRE  = 4;
   localparam int c_N_IN     = 5;

   // Width needed to hold the value max_val (at least one bit)
   function automatic int bits_for(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_experiment_sequencer_sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : 2-FF synchroniser with registered level and edge pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect (
   input  logic clock,
   input  logic reset_signal,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   // level, rise and fall all update on the same edge so they stay aligned
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= async_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign level = r_prev;
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/fsm_experiment_sequencer.sv
// ============================================================================
// fsm_experiment_sequencer : arm / align / detonate / wire-break / N-channel
// delayed trigger sequencer. Optional WAIT_WIRE watchdog enabled by
// FSM_EXPERIMENT_SEQUENCER_WIRE_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module fsm_experiment_sequencer
   import fsm_experiment_sequencer_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int N_CH         = 4,
   parameter int PHASE_SKIP   = 4,
   parameter int DET_PULSE    = 40,
   parameter int TRIG_PULSE   = 20,
   parameter int WIRE_TIMEOUT = 2_000_000
) (
   input  logic                  clock,
   input  logic                  reset_signal,
   input  logic                  start_signal,
   input  logic                  fg_signal,
   input  logic                  phase_signal,
   input  logic                  wire_signal,
   input  logic                  detector_ready,
   input  logic [N_CH*CNT_W-1:0] ch_delay,
   output logic                  detonation_signal,
   output logic [N_CH-1:0]       output_trigger,
   output logic [STATE_W-1:0]    scenario_state,
   output logic [CNT_W-1:0]      counter_out
);

   localparam int c_PH_W  = bits_for(PHASE_SKIP);
   localparam int c_DET_W = bits_for(DET_PULSE - 1);
   localparam int c_PLS_W = bits_for(TRIG_PULSE - 1);
   localparam logic [c_PH_W-1:0]  c_PHASE_SKIP = c_PH_W'(PHASE_SKIP);
   localparam logic [c_DET_W-1:0] c_DET_LAST   = c_DET_W'(DET_PULSE - 1);
   localparam logic [c_PLS_W-1:0] c_PLS_LAST   = c_PLS_W'(TRIG_PULSE - 1);

   // Reset asserts asynchronously and releases on a clock edge
   logic r_rst_meta;
   logic r_rst_n;
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   logic [c_N_IN-1:0] w_async;
   logic [c_N_IN-1:0] w_level;
   logic [c_N_IN-1:0] w_rise;
   logic [c_N_IN-1:0] w_fall;
   logic              w_unused_in;

   assign w_async = {wire_signal, phase_signal, fg_signal, detector_ready, start_signal};

   generate
      for (genvar gi = 0; gi < c_N_IN; gi++) begin : g_sync
         sync_edge_detect u_sync (
            .clock        (clock),
            .reset_signal (r_rst_n),
            .async_in     (w_async[gi]),
            .level        (w_level[gi]),
            .rise         (w_rise[gi]),
            .fall         (w_fall[gi])
         );
      end
   endgenerate

   assign w_unused_in = ^{w_level, w_rise, w_fall};

   state_t                r_state;
   state_t                w_next_state;
   logic [c_PH_W-1:0]     r_phase_cnt;
   logic [c_DET_W-1:0]    r_det_cnt;
   logic [CNT_W-1:0]      r_counter;
   logic [N_CH-1:0]       w_ch_on;
   logic [N_CH-1:0]       w_ch_fin;
   logic                  w_wd_expired;

`ifdef FSM_EXPERIMENT_SEQUENCER_WIRE_TIMEOUT_EN
   localparam int c_WD_W = bits_for(WIRE_TIMEOUT - 1);
   localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WIRE_TIMEOUT - 1);
   logic [c_WD_W-1:0] r_wd_cnt;

   always_ff @(posedge clock or negedge r_rst_n) begin
      if (!r_rst_n)
         r_wd_cnt <= '0;
      else if (r_state != ST_WAIT_WIRE)
         r_wd_cnt <= '0;
      else if (r_wd_cnt != c_WD_LAST)
         r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
   end

   assign w_wd_expired = (r_state == ST_WAIT_WIRE) && (r_wd_cnt == c_WD_LAST);
`else
   localparam int c_unused_wire_timeout = WIRE_TIMEOUT;
   assign w_wd_expired = 1'b0;
`endif

   always_ff @(posedge clock or negedge r_rst_n) begin
      if (!r_rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE:       if (w_rise[c_IN_START]) w_next_state = ST_WAIT_READY;
         ST_WAIT_READY: if (w_level[c_IN_READY]) w_next_state = ST_WAIT_PHASE;
         ST_WAIT_PHASE: begin
            if (!w_level[c_IN_READY])           w_next_state = ST_FAULT;
            else if (r_phase_cnt == c_PHASE_SKIP) w_next_state = ST_WAIT_FG;
         end
         ST_WAIT_FG: begin
            // Losing the detector outranks a simultaneous gate opening
            if (!w_level[c_IN_READY]) w_next_state = ST_FAULT;
            else if (w_rise[c_IN_FG]) w_next_state = ST_DETONATE;
         end
         ST_DETONATE:   if (r_det_cnt == c_DET_LAST) w_next_state = ST_WAIT_WIRE;
         ST_WAIT_WIRE: begin
            if (w_rise[c_IN_WIRE]) w_next_state = ST_TRIGGER;
            else if (w_wd_expired) w_next_state = ST_FAULT;
         end
         ST_TRIGGER:    if (&w_ch_fin) w_next_state = ST_DONE;
         ST_DONE:       if (!w_level[c_IN_START]) w_next_state = ST_IDLE;
         ST_FAULT:      w_next_state = ST_FAULT;
         default:       w_next_state = ST_FAULT;
      endcase
   end

   always_comb begin
      detonation_signal = (r_state == ST_DETONATE);
      output_trigger    = (r_state == ST_TRIGGER) ? w_ch_on : '0;
      scenario_state    = r_state;
   end

   assign counter_out = r_counter;

   always_ff @(posedge clock or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_phase_cnt <= '0;
         r_det_cnt   <= '0;
         r_counter   <= '0;
      end else begin
         if (r_state != ST_WAIT_PHASE)
            r_phase_cnt <= '0;
         else if (w_rise[c_IN_PHASE] && r_phase_cnt != c_PHASE_SKIP)
            r_phase_cnt <= r_phase_cnt + c_PH_W'(1);

         if (r_state != ST_DETONATE)
            r_det_cnt <= '0;
         else
            r_det_cnt <= r_det_cnt + c_DET_W'(1);

         if (r_state == ST_IDLE) begin
            if (w_rise[c_IN_START])
               r_counter <= '0;
         end else if (r_state != ST_DONE && r_state != ST_FAULT && r_counter != '1) begin
            r_counter <= r_counter + CNT_W'(1);
         end
      end
   end

   // Each channel counts its delay down to zero, then holds the pulse high
   generate
      for (genvar gc = 0; gc < N_CH; gc++) begin : g_ch
         logic [CNT_W-1:0]   r_dly;
         logic [c_PLS_W-1:0] r_pls;
         logic               r_done;

         always_ff @(posedge clock or negedge r_rst_n) begin
            if (!r_rst_n) begin
               r_dly  <= '0;
               r_pls  <= '0;
               r_done <= 1'b0;
            end else if (r_state == ST_WAIT_WIRE && w_rise[c_IN_WIRE]) begin
               r_dly  <= ch_delay[gc*CNT_W +: CNT_W];
               r_pls  <= '0;
               r_done <= 1'b0;
            end else if (r_state == ST_TRIGGER && !r_done) begin
               if (r_dly != '0)
                  r_dly <= r_dly - CNT_W'(1);
               else if (r_pls == c_PLS_LAST)
                  r_done <= 1'b1;
               else
                  r_pls <= r_pls + c_PLS_W'(1);
            end
         end

         assign w_ch_on[gc]  = (r_dly == '0) && !r_done;
         assign w_ch_fin[gc] = r_done || (w_ch_on[gc] && r_pls == c_PLS_LAST);
      end
   endgenerate

endmodule

`default_nettype wire

// File: doc/fsm_experiment_sequencer.md
Name: fsm_experiment_sequencer

Overview:
- Parametrised successor to the single-trigger experiment-phase FSM.
- Arms on start, waits for detector readiness, then aligns to a configurable number of phase edges.
- Fires the detonator on the next fast-gate opening, then waits for the wire-sensor break.
- Emits N_CH independently delayed output triggers.
- Sits between the synchronisation-block input conditioners and the detonator/detector trigger drivers.

Parameters:
- CNT_W, 32: width of counter_out and of each channel delay.
- N_CH, 4: number of output trigger channels (1..16).
- PHASE_SKIP, 4: phase rising edges counted in WAIT_PHASE before fast-gate is accepted; 0 = skip.
- DET_PULSE, 40: detonation_signal high time in clocks (≥1).
- TRIG_PULSE, 20: output_trigger[i] high time in clocks (≥1).
- WIRE_TIMEOUT, 2_000_000: clocks allowed in WAIT_WIRE (used only with the optional feature).

Ports:
- clock  in  1  system clock, 200 MHz.
- reset_signal  in  1  asynchronous, active-low reset.
- start_signal  in  1  async; rising edge arms the sequence.
- fg_signal  in  1  async fast-gate opto; rising edge = gate open.
- phase_signal  in  1  async phase reference.
- wire_signal  in  1  async wire sensor; rising edge = wire break.
- detector_ready  in  1  async level; high = detector armed.
- ch_delay  in  N_CH*CNT_W  per-channel delay after wire edge; channel i at bits [i*CNT_W +: CNT_W]; sampled at the wire edge.
- detonation_signal  out  1  detonator fire pulse.
- output_trigger  out  N_CH  per-channel trigger pulses.
- scenario_state  out  8  state code.
- counter_out  out  CNT_W  clocks since arming.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0; state IDLE.
  - Assertion mid-operation drops detonation_signal and output_trigger in the same instant, including a pulse in progress.
- Input conditioning:
  - Every async input goes through a 2-FF synchroniser, followed by an edge-detect register.
  - A pin edge sampled at clock k produces a state change visible on scenario_state at clock k+3.
- State codes: IDLE 0x00, WAIT_READY 0x01, WAIT_PHASE 0x02, WAIT_FG 0x03, DETONATE 0x04, WAIT_WIRE 0x05, TRIGGER 0x06, DONE 0x07, FAULT 0xFF.
- Transitions:
  - IDLE: start rise → WAIT_READY; counter_out cleared to 0.
  - WAIT_READY: detector_ready high → WAIT_PHASE; phase counter cleared.
  - WAIT_PHASE: count phase rises; count==PHASE_SKIP → WAIT_FG. With PHASE_SKIP=0, the next cycle enters WAIT_FG.
  - WAIT_FG: fg rise → DETONATE.
  - DETONATE: detonation_signal high for exactly DET_PULSE clocks, starting in the first DETONATE cycle; then → WAIT_WIRE.
  - WAIT_WIRE: wire rise → TRIGGER; ch_delay captured and per-channel down-counters loaded.
  - TRIGGER:
    - output_trigger[i] rises ch_delay[i] clocks after TRIGGER entry; delay 0 = first TRIGGER cycle.
    - Each pulse is high for TRIG_PULSE clocks.
    - Channels are independent and may overlap.
    - When every channel has completed → DONE.
  - DONE: synchronised start low → IDLE. If start is already low, IDLE follows the next cycle.
  - FAULT: all outputs low; held until reset.
- Faults and edges ignored:
  - detector_ready falling in WAIT_PHASE or WAIT_FG → FAULT.
  - If detector_ready falls and fg rises in the same cycle, FAULT wins and no detonation occurs.
  - Wire rise during DETONATE is ignored; no early detection.
  - Start rise outside IDLE is ignored.
  - fg and phase edges are ignored outside their own wait states.
  - Once DETONATE is entered, detector_ready is ignored.
- counter_out:
  - Increments every clock outside IDLE, DONE and FAULT.
  - Saturates at all-ones with no wrap.
  - Holds its value in DONE and FAULT.

Optional Feature:
- Macro: FSM_EXPERIMENT_SEQUENCER_WIRE_TIMEOUT_EN.
- Defined: a WAIT_WIRE watchdog.
  - Reaching WIRE_TIMEOUT clocks in WAIT_WIRE without a wire rise → FAULT.
  - If the wire edge arrives on the timeout cycle, the wire edge wins.
- Undefined: WAIT_WIRE waits indefinitely; WIRE_TIMEOUT is unused and no watchdog counter is built.

Decomposition:
- Package fsm_experiment_sequencer_pkg: state enum with the 8-bit codes above, plus STATE_W=8.
- Sub-module sync_edge_detect: 2-FF synchroniser plus rising/falling edge pulses; reset to 0. Instantiated once per async input.
- Per-channel delay/pulse counters are a generate loop inside the top module.

Test Plan:
- Nominal, N_CH=4, PHASE_SKIP=4, ch_delay={0,10,100,1000}:
  - Start, ready, 4 phase edges, fg rise, wire rise → detonation_signal high exactly 40 clocks.
  - Triggers rise 0/10/100/1000 clocks after TRIGGER entry, each 20 clocks wide.
  - DONE=0x07; IDLE after start drops.
- Ready drop: detector_ready falls in WAIT_FG, same cycle as fg rise → scenario_state 0xFF; detonation_signal never asserts.
- Reset at clock 20 of the detonation pulse → detonation_signal 0 immediately; state 0x00; counter_out 0.
- Input latency: start rise sampled at clock k → scenario_state 0x01 at k+3. Start re-pulsed in WAIT_PHASE → no effect.
- PHASE_SKIP=0, ch_delay all 0 → WAIT_FG one cycle after WAIT_PHASE; all N_CH triggers rise in the same cycle.
- With FSM_EXPERIMENT_SEQUENCER_WIRE_TIMEOUT_EN and WIRE_TIMEOUT=1000, no wire edge → FAULT after 1000 clocks in WAIT_WIRE. Without the macro, still 0x05 after 10000 clocks.
